led_status_pwm: RTL and testbench

- Parametrised successor to the two-RGB CPU status indicator on the board user interface.
- Tracks CPU lifecycle (load, run, halt, fault) and execution mode. Drives two RGB LEDs with PWM brightness, slow/fast blink modes and a retriggerable step-flash.
- Sits between the CPU control/UART loader status signals and the board RGB pins.

---
 rtl/led_status_pkg.sv | 31 +++
 rtl/led_status_pwm_if.sv | 30 +++
 rtl/led_pwm_gen.sv | 37 +++
 rtl/led_status_pwm.sv | 115 +++++++++++
 tb/tb_led_status_pwm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/led_status_pkg.sv
// Shared encodings for the CPU status LED block: lifecycle states and RGB colours.
package led_status_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOADED = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd2;
    localparam logic [STATE_W-1:0] ST_HALT   = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        StIdle   = ST_IDLE,
        StLoaded = ST_LOADED,
        StRun    = ST_RUN,
        StHalt   = ST_HALT,
        StFault  = ST_FAULT
    } lc_state_e;

    // Colours are {R,G,B}
    localparam logic [2:0] COL_OFF   = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;

    // Pass a colour through only while the enable is high.
    function automatic logic [2:0] gate_colour(input logic [2:0] col, input logic en);
        return en ? col : COL_OFF;
    endfunction

endpackage

// File: rtl/led_status_pwm_if.sv
// Status inputs from CPU control / loader and RGB/debug outputs of the LED block.
interface led_status_pwm_if #(
    parameter int unsigned PWM_BITS = 8
);
    logic                i_instr_transmit_done;
    logic                i_start_cpu;
    logic                i_halt;
    logic                i_fault;
    logic                i_clear;
    logic                i_step_execution;
    logic                i_step_pulse;
    logic [PWM_BITS-1:0] i_brightness;
    logic [2:0]          o_rgb1;
    logic [2:0]          o_rgb2;
    logic [2:0]          o_state;

    // Driver side (CPU/status logic, or a bench)
    modport master (
        output i_instr_transmit_done, i_start_cpu, i_halt, i_fault, i_clear,
               i_step_execution, i_step_pulse, i_brightness,
        input  o_rgb1, o_rgb2, o_state
    );

    // LED block side
    modport slave (
        input  i_instr_transmit_done, i_start_cpu, i_halt, i_fault, i_clear,
               i_step_execution, i_step_pulse, i_brightness,
        output o_rgb1, o_rgb2, o_state
    );
endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM and blink timebase with period-aligned brightness latch.
module led_pwm_gen #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned BLINK_LOG2 = 24
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PWM_BITS-1:0] i_brightness,
    output logic                o_pwm_on,
    output logic                o_slow_ph,
    output logic                o_fast_ph
);

    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [PWM_BITS-1:0]   r_bright;
    logic [BLINK_LOG2-1:0] r_blink_cnt;

    // Counters wrap naturally; brightness only changes at the period start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt   <= '0;
            r_bright    <= '1;
            r_blink_cnt <= '0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
            r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1);
            if (r_pwm_cnt == '0) begin
                r_bright <= i_brightness;
            end
        end
    end

    assign o_pwm_on  = (r_pwm_cnt < r_bright);
    assign o_slow_ph = r_blink_cnt[BLINK_LOG2-1];
    assign o_fast_ph = r_blink_cnt[BLINK_LOG2-3];

endmodule

// File: rtl/led_status_pwm.sv
// CPU lifecycle tracker driving two PWM-dimmed RGB status LEDs.
module led_status_pwm
    import led_status_pkg::*;
#(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned BLINK_LOG2   = 24,
    parameter int unsigned FLASH_CYCLES = 2_000_000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    led_status_pwm_if.slave bus
);

    localparam int unsigned FLASH_W = $clog2(FLASH_CYCLES + 1);

    lc_state_e          r_state;
    lc_state_e          w_state_nxt;
    logic [FLASH_W-1:0] r_flash;
    logic [2:0]         r_rgb1;
    logic [2:0]         r_rgb2;
    logic [2:0]         w_col1;
    logic [2:0]         w_col2;
    logic               w_pwm_on;
    logic               w_slow_ph;
    logic               w_fast_ph;

    led_pwm_gen #(
        .PWM_BITS   (PWM_BITS),
        .BLINK_LOG2 (BLINK_LOG2)
    ) u_pwm_gen (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_brightness (bus.i_brightness),
        .o_pwm_on     (w_pwm_on),
        .o_slow_ph    (w_slow_ph),
        .o_fast_ph    (w_fast_ph)
    );

    // Lifecycle state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lifecycle next state; clear overrides everything, fault beats halt.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_clear) begin
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle:   if (bus.i_instr_transmit_done) w_state_nxt = StLoaded;
                StLoaded: if (bus.i_start_cpu)           w_state_nxt = StRun;
                StRun: begin
                    if (bus.i_fault)     w_state_nxt = StFault;
                    else if (bus.i_halt) w_state_nxt = StHalt;
                end
                StHalt:   if (bus.i_fault)               w_state_nxt = StFault;
                StFault:  w_state_nxt = StFault;
                default:  w_state_nxt = StIdle;
            endcase
        end
    end

    // Step-flash timer: retriggerable, only armed by pulses while running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flash <= '0;
        end else if (bus.i_clear) begin
            r_flash <= '0;
        end else if (bus.i_step_pulse && (r_state == StRun)) begin
            r_flash <= FLASH_W'(FLASH_CYCLES);
        end else if (r_flash != '0) begin
            r_flash <= r_flash - FLASH_W'(1);
        end
    end

    // Colour selection for both LEDs before PWM gating.
    always_comb begin
        w_col1 = COL_BLUE;
        if (r_flash != '0) begin
            w_col1 = COL_GREEN;
        end else if (bus.i_step_execution) begin
            w_col1 = COL_RED;
        end

        w_col2 = COL_OFF;
        case (r_state)
            StLoaded: w_col2 = COL_GREEN;
            StRun:    w_col2 = gate_colour(COL_BLUE, !bus.i_step_execution || w_slow_ph);
            StHalt:   w_col2 = COL_RED;
            StFault:  w_col2 = gate_colour(COL_RED, w_fast_ph);
            default:  w_col2 = COL_OFF;
        endcase
    end

    // Registered, PWM-gated LED drive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb1 <= COL_OFF;
            r_rgb2 <= COL_OFF;
        end else begin
            r_rgb1 <= gate_colour(w_col1, w_pwm_on);
            r_rgb2 <= gate_colour(w_col2, w_pwm_on);
        end
    end

    assign bus.o_rgb1  = r_rgb1;
    assign bus.o_rgb2  = r_rgb2;
    assign bus.o_state = r_state;

endmodule

// File: tb/tb_led_status_pwm.sv
// Bench for led_status_pwm: cycle model from the behavioural rules plus literal pins.
module tb_led_status_pwm;

    localparam int PB = 4;
    localparam int BL = 4;
    localparam int FC = 5;
    localparam int PERIOD = 2 ** PB;
    localparam int BPERIOD = 2 ** BL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_status_pwm_if #(.PWM_BITS(PB)) bus ();

    led_status_pwm #(
        .PWM_BITS     (PB),
        .BLINK_LOG2   (BL),
        .FLASH_CYCLES (FC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles since reset give both timebases; state/flash from the rules.
    int m_cyc, m_bright, m_state, m_flash;
    int exp_rgb1, exp_rgb2, exp_state;

    always @(posedge clk or negedge rst_n) begin
        int  pwm, blink, c1, c2;
        bit  on, slow, fast;
        if (!rst_n) begin
            m_cyc = 0; m_bright = PERIOD - 1; m_state = 0; m_flash = 0;
            exp_rgb1 = 0; exp_rgb2 = 0; exp_state = 0;
        end else begin
            pwm   = m_cyc % PERIOD;
            blink = m_cyc % BPERIOD;
            on    = pwm < m_bright;
            slow  = blink >= BPERIOD / 2;
            fast  = ((blink / 2) % 2) == 1;
            if (m_flash > 0)               c1 = 3'b010;
            else if (bus.i_step_execution) c1 = 3'b100;
            else                           c1 = 3'b001;
            case (m_state)
                1:       c2 = 3'b010;
                2:       c2 = (!bus.i_step_execution || slow) ? 3'b001 : 0;
                3:       c2 = 3'b100;
                4:       c2 = fast ? 3'b100 : 0;
                default: c2 = 0;
            endcase
            exp_rgb1 = on ? c1 : 0;
            exp_rgb2 = on ? c2 : 0;
            if (bus.i_clear)                          m_flash = 0;
            else if (bus.i_step_pulse && m_state == 2) m_flash = FC;
            else if (m_flash > 0)                     m_flash = m_flash - 1;
            if (bus.i_clear) m_state = 0;
            else case (m_state)
                0: m_state = bus.i_instr_transmit_done ? 1 : 0;
                1: m_state = bus.i_start_cpu ? 2 : 1;
                2: m_state = bus.i_fault ? 4 : (bus.i_halt ? 3 : 2);
                3: m_state = bus.i_fault ? 4 : 3;
                4: m_state = 4;
                default: m_state = 0;
            endcase
            if (pwm == 0) m_bright = int'(bus.i_brightness);
            m_cyc++;
            exp_state = m_state;
        end
    end

    // Compare every cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_rgb1", int'(bus.o_rgb1), exp_rgb1);
            check("model_rgb2", int'(bus.o_rgb2), exp_rgb2);
            check("model_state", int'(bus.o_state), exp_state);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic zero_inputs();
        bus.i_instr_transmit_done = 0; bus.i_start_cpu = 0; bus.i_halt = 0;
        bus.i_fault = 0; bus.i_clear = 0; bus.i_step_pulse = 0;
    endtask

    // Count cycles in a 16-cycle window whose o_rgb2 equals col.
    task automatic count_rgb2(input logic [2:0] col, output int n);
        n = 0;
        repeat (PERIOD) begin
            if (bus.o_rgb2 == col) n++;
            tick(1);
        end
    endtask

    initial begin
        int n;
        zero_inputs();
        bus.i_step_execution = 0;
        bus.i_brightness = 4'd15;
        rst_n = 0;
        #12;
        check("reset_state", int'(bus.o_state), 0);
        check("reset_rgb1", int'(bus.o_rgb1), 0);
        check("reset_rgb2", int'(bus.o_rgb2), 0);
        @(negedge clk) rst_n = 1;
        tick(3);

        bus.i_instr_transmit_done = 1; tick(1); bus.i_instr_transmit_done = 0;
        check("load_state", int'(bus.o_state), 1);
        tick(1);
        count_rgb2(3'b010, n);
        check("loaded_green_cycles", n, 15);

        bus.i_halt = 1; tick(1); bus.i_halt = 0;
        check("halt_in_loaded", int'(bus.o_state), 1);

        bus.i_start_cpu = 1; tick(1); bus.i_start_cpu = 0;
        check("run_state", int'(bus.o_state), 2);
        tick(1);
        count_rgb2(3'b001, n);
        check("run_blue_cycles", n, 15);

        bus.i_brightness = 4'd0; tick(2 * PERIOD + 2);
        n = 0;
        repeat (PERIOD) begin
            if ((bus.o_rgb1 | bus.o_rgb2) != 0) n++;
            tick(1);
        end
        check("bright0_on_cycles", n, 0);

        bus.i_brightness = 4'd4; tick(2 * PERIOD + 2);
        count_rgb2(3'b001, n);
        check("bright4_on_cycles", n, 4);

        // Step mode: blue only in upper half of the blink period, minus pwm_cnt==15.
        bus.i_brightness = 4'd15; bus.i_step_execution = 1; tick(2 * PERIOD + 2);
        count_rgb2(3'b001, n);
        check("step_blue_cycles", n, 7);
        bus.i_step_pulse = 1; tick(1); bus.i_step_pulse = 0;
        tick(2);
        bus.i_step_pulse = 1; tick(1); bus.i_step_pulse = 0;
        tick(12);

        bus.i_step_execution = 0;
        bus.i_halt = 1; bus.i_fault = 1; tick(1); zero_inputs();
        check("fault_wins", int'(bus.o_state), 4);
        tick(1);
        count_rgb2(3'b100, n);
        check("fault_red_cycles", n, 7);
        bus.i_halt = 1; tick(1); bus.i_halt = 0;
        check("halt_in_fault", int'(bus.o_state), 4);
        bus.i_clear = 1; tick(1); bus.i_clear = 0;
        check("clear_state", int'(bus.o_state), 0);
        tick(1);
        check("clear_rgb2", int'(bus.o_rgb2), 0);

        bus.i_instr_transmit_done = 1; bus.i_start_cpu = 1; tick(1); zero_inputs();
        check("done_start_together", int'(bus.o_state), 1);
        tick(2);

        // Random traffic, checked cycle by cycle against the model.
        repeat (800) begin
            bus.i_instr_transmit_done = ($urandom % 6) == 0;
            bus.i_start_cpu           = ($urandom % 6) == 0;
            bus.i_halt                = ($urandom % 20) == 0;
            bus.i_fault               = ($urandom % 30) == 0;
            bus.i_clear               = ($urandom % 40) == 0;
            bus.i_step_pulse          = ($urandom % 5) == 0;
            if (($urandom % 24) == 0) bus.i_step_execution = ~bus.i_step_execution;
            if (($urandom % 40) == 0) bus.i_brightness = 4'($urandom_range(0, 15));
            tick(1);
        end
        zero_inputs();
        bus.i_brightness = 4'd15;

        // Asynchronous reset in the middle of RUN.
        bus.i_clear = 1; tick(1); bus.i_clear = 0;
        bus.i_instr_transmit_done = 1; tick(1); bus.i_instr_transmit_done = 0;
        bus.i_start_cpu = 1; tick(1); bus.i_start_cpu = 0;
        tick(5);
        check("pre_reset_run", int'(bus.o_state), 2);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("async_rst_state", int'(bus.o_state), 0);
        check("async_rst_rgb1", int'(bus.o_rgb1), 0);
        check("async_rst_rgb2", int'(bus.o_rgb2), 0);
        @(negedge clk) rst_n = 1;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
